// File: rtl/riscv_def.sv
// Shared core definitions used by the data-memory controller:
// access size encodings, controller FSM states, and the alignment check.
package riscv_def;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        DM_IDLE = 2'b00,
        DM_BUSY = 2'b01,
        DM_RESP = 2'b10
    } dm_state_e;

    // True when the size code is reserved or the low address bits do not
    // match the natural alignment of the access.
    function automatic logic align_err(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        case (size)
            SIZE_B:  bad = 1'b0;
            SIZE_H:  bad = lane[0];
            SIZE_W:  bad = (lane != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane steering between a 32-bit memory word and a
// right-aligned store/load value. Produces the merged store word and the
// sign- or zero-extended load value for the addressed lane(s).
module mem_lane_align
    import riscv_def::*;
(
    input  logic [31:0] old_word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  lane_i,
    input  logic [1:0]  size_i,
    input  logic        sign_i,
    output logic [31:0] merged_o,
    output logic [31:0] load_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Merge store data into the addressed lanes and extract/extend the load lanes.
    always_comb begin
        merged_o = old_word_i;
        load_o   = '0;
        byte_sel = old_word_i[{lane_i, 3'b000} +: 8];
        half_sel = old_word_i[{lane_i[1], 4'b0000} +: 16];
        case (size_i)
            SIZE_B: begin
                merged_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
                load_o = {{24{sign_i & byte_sel[7]}}, byte_sel};
            end
            SIZE_H: begin
                merged_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
                load_o = {{16{sign_i & half_sel[15]}}, half_sel};
            end
            SIZE_W: begin
                merged_o = wdata_i;
                load_o   = old_word_i;
            end
            default: begin
                merged_o = old_word_i;
                load_o   = '0;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: data-port memory with programmable wait states and a
// one-cycle ready pulse. Supports byte/halfword/word stores and loads with
// sign/zero extension, flags misaligned, reserved-size and out-of-range
// accesses, and exposes one fixed word combinationally on verify.
module data_mem_ctrl
    import riscv_def::*;
#(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned LATENCY     = 0,
    parameter logic [31:0] VERIFY_ADDR = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ready,
    output logic        err,
    output logic [31:0] verify
);

    localparam int unsigned   AW       = $clog2(DEPTH);
    localparam logic [AW-1:0] VIDX     = VERIFY_ADDR[AW+1:2];
    localparam logic [2:0]    LAT_INIT = 3'(LATENCY);

    // Control state
    dm_state_e   state_q;
    logic [2:0]  cnt_q;
    logic        ready_q;
    logic        err_q;
    logic [31:0] rdata_q;

    // Latched request, held from acceptance until the commit edge
    logic        we_q;
    logic        sign_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic [31:0] mem_q [DEPTH];

    logic [AW-1:0] word_idx;
    logic [31:0]   old_word;
    logic [31:0]   merged_word;
    logic [31:0]   load_word;
    logic          range_err;
    logic          req_err;
    logic          accept;
    logic          commit;

    // Upper address bits only feed the range check; they never alias into the index.
    assign word_idx  = addr_q[AW+1:2];
    assign old_word  = mem_q[word_idx];
    assign range_err = ((addr_q >> (AW + 2)) != 32'd0);
    assign req_err   = align_err(size_q, addr_q[1:0]) | range_err;
    assign accept    = (state_q == DM_IDLE) && ce && !rst;
    assign commit    = (state_q == DM_BUSY) && (cnt_q == 3'd0);

    mem_lane_align u_align (
        .old_word_i (old_word),
        .wdata_i    (wdata_q),
        .lane_i     (addr_q[1:0]),
        .size_i     (size_q),
        .sign_i     (sign_q),
        .merged_o   (merged_word),
        .load_o     (load_word)
    );

    // Request FSM: accept, count wait states, commit, then one response cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DM_IDLE;
            cnt_q   <= 3'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            case (state_q)
                DM_IDLE: begin
                    if (ce) begin
                        cnt_q   <= LAT_INIT;
                        state_q <= DM_BUSY;
                    end
                end
                DM_BUSY: begin
                    if (cnt_q != 3'd0) begin
                        cnt_q <= cnt_q - 3'd1;
                    end else begin
                        ready_q <= 1'b1;
                        err_q   <= req_err;
                        rdata_q <= (req_err || we_q) ? 32'd0 : load_word;
                        state_q <= DM_RESP;
                    end
                end
                DM_RESP: begin
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    rdata_q <= 32'd0;
                    state_q <= DM_IDLE;
                end
                default: begin
                    state_q <= DM_IDLE;
                end
            endcase
        end
    end

    // Capture the request fields on acceptance; they stay frozen until the next one.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= we;
            sign_q  <= sign;
            size_q  <= size;
            addr_q  <= addr;
            wdata_q <= data_i;
        end
    end

    // Array write at the commit edge; reset in the same cycle suppresses it.
    always_ff @(posedge clk) begin
        if (!rst && commit && we_q && !req_err) begin
            mem_q[word_idx] <= merged_word;
        end
    end

    assign data_o = rdata_q;
    assign ready  = ready_q;
    assign err    = err_q;
    assign verify = mem_q[VIDX];

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: two instances (LATENCY 0 and 3) checked every
// cycle against a transaction-level memory model, plus directed literals.
`timescale 1ns/1ps
module tb_data_mem_ctrl;
    import riscv_def::*;

    localparam int unsigned DEPTH = 256;
    localparam logic [31:0] VA    = 32'h0000_0100;
    localparam int          VIDX  = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_v  [2];
    logic        ce_v   [2];
    logic        we_v   [2];
    logic        sign_v [2];
    logic [31:0] addr_v [2];
    logic [31:0] wd_v   [2];
    logic [1:0]  size_v [2];
    logic [31:0] rd_v   [2];
    logic [31:0] ver_v  [2];
    logic        rdy_v  [2];
    logic        err_v  [2];

    data_mem_ctrl #(.DEPTH(DEPTH), .LATENCY(0), .VERIFY_ADDR(VA)) dut0 (
        .clk(clk), .rst(rst_v[0]), .ce(ce_v[0]), .we(we_v[0]), .addr(addr_v[0]),
        .size(size_v[0]), .sign(sign_v[0]), .data_i(wd_v[0]), .data_o(rd_v[0]),
        .ready(rdy_v[0]), .err(err_v[0]), .verify(ver_v[0])
    );

    data_mem_ctrl #(.DEPTH(DEPTH), .LATENCY(3), .VERIFY_ADDR(VA)) dut3 (
        .clk(clk), .rst(rst_v[1]), .ce(ce_v[1]), .we(we_v[1]), .addr(addr_v[1]),
        .size(size_v[1]), .sign(sign_v[1]), .data_i(wd_v[1]), .data_o(rd_v[1]),
        .ready(rdy_v[1]), .err(err_v[1]), .verify(ver_v[1])
    );

    int nvec   = 0;
    int nfail  = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s dut%0d cycle %0d: got %08h expected %08h", nm, d, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] mmem   [2][DEPTH];
    bit          mknown [2][DEPTH];
    bit          pend   [2];
    int          cedge  [2];
    int          free_at[2];
    logic        rq_we  [2];
    logic        rq_sg  [2];
    logic [31:0] rq_a   [2];
    logic [31:0] rq_wd  [2];
    logic [1:0]  rq_s   [2];
    bit          er     [2];
    bit          ee     [2];
    bit          dc     [2];
    logic [31:0] ed     [2];

    function automatic int lat_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic bit is_bad(input logic [31:0] a, input logic [1:0] s);
        if (a >= 32'(DEPTH * 4)) return 1'b1;
        if (s == 2'd3) return 1'b1;
        if (s == 2'd1) return (a % 2) != 0;
        if (s == 2'd2) return (a % 4) != 0;
        return 1'b0;
    endfunction

    task automatic model_access(input int d);
        logic [31:0] a, old, mask, v;
        int idx, sh;
        a     = rq_a[d];
        er[d] = 1'b1;
        ee[d] = 1'b0;
        ed[d] = 32'd0;
        dc[d] = 1'b1;
        if (is_bad(a, rq_s[d])) begin
            ee[d] = 1'b1;
            return;
        end
        idx = int'(a / 4);
        old = mmem[d][idx];
        if (rq_s[d] == 2'd0) begin
            sh = int'(a % 4) * 8;  mask = 32'h0000_00FF << sh;
        end else if (rq_s[d] == 2'd1) begin
            sh = int'((a / 2) % 2) * 16;  mask = 32'h0000_FFFF << sh;
        end else begin
            sh = 0;  mask = 32'hFFFF_FFFF;
        end
        if (rq_we[d]) begin
            mmem[d][idx] = (old & ~mask) | ((rq_wd[d] << sh) & mask);
            if (rq_s[d] == 2'd2) mknown[d][idx] = 1'b1;
            dc[d] = 1'b0;
        end else begin
            v = (old & mask) >> sh;
            if (rq_sg[d]) begin
                if (rq_s[d] == 2'd0 && v >= 32'd128)   v = v - 32'd256;
                if (rq_s[d] == 2'd1 && v >= 32'd32768) v = v - 32'd65536;
            end
            ed[d] = v;
            dc[d] = mknown[d][idx];
        end
    endtask

    // Model advances on each rising edge from the inputs sampled there.
    always @(posedge clk) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            er[d] = 1'b0; ee[d] = 1'b0; ed[d] = 32'd0; dc[d] = 1'b1;
            if (rst_v[d]) begin
                pend[d]    = 1'b0;
                free_at[d] = cyc + 1;
            end else if (pend[d]) begin
                if (cyc == cedge[d]) begin
                    model_access(d);
                    pend[d]    = 1'b0;
                    free_at[d] = cyc + 2;
                end
            end else if (cyc >= free_at[d] && ce_v[d] === 1'b1) begin
                rq_we[d] = we_v[d];  rq_sg[d] = sign_v[d];  rq_a[d] = addr_v[d];
                rq_wd[d] = wd_v[d];  rq_s[d]  = size_v[d];
                cedge[d] = cyc + 1 + lat_of(d);
                pend[d]  = 1'b1;
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                chk("ready", d, {31'd0, rdy_v[d]}, {31'd0, er[d]});
                chk("err", d, {31'd0, err_v[d]}, {31'd0, ee[d]});
                if (dc[d]) chk("data_o", d, rd_v[d], ed[d]);
                if (mknown[d][VIDX]) chk("verify", d, ver_v[d], mmem[d][VIDX]);
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] r_d;
    logic        r_e;
    int          r_lat;

    task automatic do_req(input int d, input logic w, input logic [31:0] a, input logic [1:0] s,
                          input logic sg, input logic [31:0] wd, input bit hold,
                          output logic [31:0] rd, output logic e, output int lat);
        we_v[d] = w;  addr_v[d] = a;  size_v[d] = s;  sign_v[d] = sg;  wd_v[d] = wd;
        ce_v[d] = 1'b1;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (rdy_v[d] === 1'b1) break;
        end
        chk("ready_timeout", d, {31'd0, rdy_v[d]}, 32'd1);
        rd = rd_v[d];
        e  = err_v[d];
        if (!hold) ce_v[d] = 1'b0;
    endtask

    task automatic req(input int d, input logic w, input logic [31:0] a, input logic [1:0] s,
                       input logic sg, input logic [31:0] wd);
        @(negedge clk);
        do_req(d, w, a, s, sg, wd, 1'b0, r_d, r_e, r_lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int   lat2;
        bit   saw;
        logic [31:0] a;
        logic [1:0]  s;

        for (int d = 0; d < 2; d++) begin
            rst_v[d] = 1'b1;  ce_v[d] = 1'b1;  we_v[d] = 1'b0;  sign_v[d] = 1'b0;
            addr_v[d] = 32'd0;  wd_v[d] = 32'd0;  size_v[d] = SIZE_W;
        end
        @(negedge clk);
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            rst_v[d] = 1'b0;  ce_v[d] = 1'b0;
        end

        // LATENCY 0: word store/load and byte/halfword lanes
        req(0, 1'b1, 32'h10, SIZE_W, 1'b0, 32'h1234_5678);  chk("lat_store", 0, r_lat, 2);
        req(0, 1'b0, 32'h10, SIZE_W, 1'b0, 32'h0);          chk("lat_load", 0, r_lat, 2);
        chk("ld_word", 0, r_d, 32'h1234_5678);
        req(0, 1'b1, 32'h13, SIZE_B, 1'b0, 32'h0000_00AB);
        req(0, 1'b0, 32'h13, SIZE_B, 1'b1, 32'h0);          chk("ld_byte_s", 0, r_d, 32'hFFFF_FFAB);
        req(0, 1'b0, 32'h13, SIZE_B, 1'b0, 32'h0);          chk("ld_byte_u", 0, r_d, 32'h0000_00AB);
        req(0, 1'b0, 32'h10, SIZE_W, 1'b0, 32'h0);          chk("ld_word_b", 0, r_d, 32'hAB34_5678);
        req(0, 1'b1, 32'h10, SIZE_H, 1'b0, 32'h0000_BEEF);
        req(0, 1'b0, 32'h10, SIZE_W, 1'b1, 32'h0);          chk("ld_word_h", 0, r_d, 32'hAB34_BEEF);

        // Error responses
        req(0, 1'b0, 32'h102, SIZE_W, 1'b0, 32'h0);
        chk("mis_err", 0, {31'd0, r_e}, 32'd1);  chk("mis_data", 0, r_d, 32'd0);
        req(0, 1'b1, 32'h0, SIZE_W, 1'b0, 32'hCAFE_F00D);
        req(0, 1'b1, 32'(DEPTH * 4), SIZE_W, 1'b0, 32'h1111_1111);
        chk("rng_err", 0, {31'd0, r_e}, 32'd1);
        req(0, 1'b0, 32'h0, SIZE_W, 1'b0, 32'h0);           chk("rng_nowrite", 0, r_d, 32'hCAFE_F00D);

        // Verify tap and reset abort in the commit cycle
        req(0, 1'b1, VA, SIZE_W, 1'b0, 32'h0000_0055);     chk("verify_st", 0, ver_v[0], 32'h0000_0055);
        @(negedge clk);
        we_v[0] = 1'b1;  addr_v[0] = VA;  size_v[0] = SIZE_W;  wd_v[0] = 32'h0000_0077;  ce_v[0] = 1'b1;
        @(negedge clk);
        rst_v[0] = 1'b1;  ce_v[0] = 1'b0;
        saw = (rdy_v[0] === 1'b1);
        @(negedge clk);
        rst_v[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (rdy_v[0] === 1'b1) saw = 1'b1;
            @(negedge clk);
        end
        chk("abort_ready", 0, {31'd0, saw}, 32'd0);
        chk("abort_verify", 0, ver_v[0], 32'h0000_0055);

        // LATENCY 3 with ce held through the response cycle
        @(negedge clk);
        do_req(1, 1'b1, 32'h20, SIZE_W, 1'b0, 32'hA5A5_0F0F, 1'b1, r_d, r_e, r_lat);
        chk("lat3_first", 1, r_lat, 5);
        lat2 = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat2++;
            if (rdy_v[1] === 1'b1) break;
        end
        ce_v[1] = 1'b0;
        chk("lat3_second", 1, lat2, 6);
        req(1, 1'b0, 32'h20, SIZE_W, 1'b0, 32'h0);
        chk("lat3_load", 1, r_d, 32'hA5A5_0F0F);  chk("lat3_lat", 1, r_lat, 5);

        // Randomised traffic on both instances
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 16; w++) req(d, 1'b1, 32'(w * 4), SIZE_W, 1'b0, $urandom);
            req(d, 1'b1, VA, SIZE_W, 1'b0, $urandom);
            for (int n = 0; n < 60; n++) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4, 5, 6: a = 32'($urandom_range(0, 63));
                    7:       a = VA + 32'($urandom_range(0, 3));
                    8:       a = 32'(DEPTH * 4) + 32'($urandom_range(0, 63));
                    default: a = $urandom;
                endcase
                s = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                repeat ($urandom_range(0, 2)) @(negedge clk);
                do_req(d, 1'($urandom_range(0, 1)), a, s, 1'($urandom_range(0, 1)), $urandom,
                       1'b0, r_d, r_e, r_lat);
            end
        end

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
